// File: rtl/scm_pkg.sv
// Shared width helpers for the SCM FIFO controller and its pointer counters.
package scm_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/scm_wrap_cnt.sv
// Row pointer that wraps from DEPTH-1 back to 0; DEPTH need not be a power of two.
module scm_wrap_cnt
  import scm_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        inc_i,
  output logic [ptr_width(DEPTH)-1:0] cnt_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/scm_fifo_ctrl.sv
// Valid/ready FIFO sequencing for a latch-based 1R1W SCM: pointers, occupancy
// and the two-cycle write-to-read visibility delay of the SCM write path.
module scm_fifo_ctrl
  import scm_pkg::*;
#(
  parameter int WORD_WIDTH = 25,
  parameter int DEPTH      = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [WORD_WIDTH-1:0]       in_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [WORD_WIDTH-1:0]       out_data_o,
  output logic [cnt_width(DEPTH)-1:0] usage_o,
  output logic                        scm_we_o,
  output logic [ptr_width(DEPTH)-1:0] scm_waddr_o,
  output logic [WORD_WIDTH-1:0]       scm_wdata_o,
  output logic [ptr_width(DEPTH)-1:0] scm_raddr_o,
  input  logic [WORD_WIDTH-1:0]       scm_rdata_i
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          push;
  logic          pop;
  logic          commit_p1;
  logic [CW-1:0] usage_q;
  logic [CW-1:0] usage_d;
  logic [CW-1:0] vis_q;
  logic [CW-1:0] vis_d;

  // Ready is a function of occupancy only, so out_ready_i never reaches in_ready_o.
  assign in_ready_o  = (usage_q < FULL) & ~flush_i;
  assign out_valid_o = (vis_q != '0) & ~flush_i;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  assign scm_we_o    = push & rst_ni;
  assign scm_wdata_o = in_data_i;
  assign out_data_o  = scm_rdata_i;
  assign usage_o     = usage_q;

  scm_wrap_cnt #(.DEPTH(DEPTH)) u_wptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (push),
    .cnt_o  (scm_waddr_o)
  );

  scm_wrap_cnt #(.DEPTH(DEPTH)) u_rptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (pop),
    .cnt_o  (scm_raddr_o)
  );

  always_comb begin
    usage_d = usage_q;
    vis_d   = vis_q;
    if (flush_i) begin
      usage_d = '0;
      vis_d   = '0;
    end else begin
      case ({push, pop})
        2'b10:   usage_d = usage_q + CW'(1);
        2'b01:   usage_d = usage_q - CW'(1);
        default: usage_d = usage_q;
      endcase
      case ({commit_p1, pop})
        2'b10:   vis_d = vis_q + CW'(1);
        2'b01:   vis_d = vis_q - CW'(1);
        default: vis_d = vis_q;
      endcase
    end
  end

  // Stage p1: push seen one cycle ago, becomes readable after this edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_p1 <= 1'b0;
      usage_q   <= '0;
      vis_q     <= '0;
    end else begin
      commit_p1 <= push & ~flush_i;
      usage_q   <= usage_d;
      vis_q     <= vis_d;
    end
  end

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Bench for scm_fifo_ctrl: directed vector table on DEPTH=5, random traffic on DEPTH=64.
module tb_scm_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  // DEPTH=5 instance
  logic        a_iv, a_ir, a_ov, a_or, a_fl, a_we;
  logic [24:0] a_din, a_dout, a_wdata, a_rdata;
  logic [2:0]  a_usage, a_waddr, a_raddr;
  // DEPTH=64 instance
  logic        b_iv, b_ir, b_ov, b_or, b_fl, b_we;
  logic [24:0] b_din, b_dout, b_wdata, b_rdata;
  logic [6:0]  b_usage;
  logic [5:0]  b_waddr, b_raddr;

  scm_fifo_ctrl #(.WORD_WIDTH(25), .DEPTH(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(a_fl),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_din),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_dout),
    .usage_o(a_usage), .scm_we_o(a_we), .scm_waddr_o(a_waddr),
    .scm_wdata_o(a_wdata), .scm_raddr_o(a_raddr), .scm_rdata_i(a_rdata)
  );

  scm_fifo_ctrl #(.WORD_WIDTH(25), .DEPTH(64)) dut64 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(b_fl),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_din),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_dout),
    .usage_o(b_usage), .scm_we_o(b_we), .scm_waddr_o(b_waddr),
    .scm_wdata_o(b_wdata), .scm_raddr_o(b_raddr), .scm_rdata_i(b_rdata)
  );

  // SCM models: registered write buffer, then array update one edge later
  logic [24:0] mem5 [0:7];
  logic        wb5_v;
  logic [2:0]  wb5_a;
  logic [24:0] wb5_d;
  logic [24:0] mem64 [0:63];
  logic        wb64_v;
  logic [5:0]  wb64_a;
  logic [24:0] wb64_d;

  always @(posedge clk) begin
    wb5_v  <= a_we;
    wb5_a  <= a_waddr;
    wb5_d  <= a_wdata;
    if (wb5_v) mem5[wb5_a] <= wb5_d;
    wb64_v <= b_we;
    wb64_a <= b_waddr;
    wb64_d <= b_wdata;
    if (wb64_v) mem64[wb64_a] <= wb64_d;
  end
  assign a_rdata = mem5[a_raddr];
  assign b_rdata = mem64[b_raddr];

  int checks = 0;
  int failures = 0;
  logic [24:0] q5[$];
  logic [24:0] q64[$];

  typedef struct {
    logic        iv, ordy, fl;
    logic [24:0] data;
    logic        ir, ov;
    logic [2:0]  usage;
    logic        we;
    logic [2:0]  wa, ra;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int iv, int ordy, int fl, int data, int ir, int ov,
                              int u, int we, int wa, int ra);
    vec_t v;
    v.iv = iv[0]; v.ordy = ordy[0]; v.fl = fl[0]; v.data = data[24:0];
    v.ir = ir[0]; v.ov = ov[0]; v.usage = u[2:0]; v.we = we[0];
    v.wa = wa[2:0]; v.ra = ra[2:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step5(input vec_t v, input int idx);
    string s;
    logic [24:0] e;
    @(negedge clk);
    a_iv = v.iv; a_or = v.ordy; a_fl = v.fl; a_din = v.data;
    #1;
    s = $sformatf("d5[%0d]", idx);
    chk({s, " in_ready"},  32'(a_ir),    32'(v.ir));
    chk({s, " out_valid"}, 32'(a_ov),    32'(v.ov));
    chk({s, " usage"},     32'(a_usage), 32'(v.usage));
    chk({s, " we"},        32'(a_we),    32'(v.we));
    chk({s, " waddr"},     32'(a_waddr), 32'(v.wa));
    chk({s, " raddr"},     32'(a_raddr), 32'(v.ra));
    if (a_ov && a_or) begin
      if (q5.size() == 0) chk({s, " pop_on_empty_sb"}, 32'(1), 32'(0));
      else begin
        e = q5.pop_front();
        chk({s, " data"}, 32'(a_dout), 32'(e));
      end
    end
    if (a_iv && a_ir) q5.push_back(a_din);
    if (a_fl) q5.delete();
  endtask

  initial begin
    int mu, mv, mc, u;
    bit push, pop, exp_ir, exp_ov;
    logic [24:0] e;

    rst_ni = 1'b0;
    a_iv = 1'b1; a_or = 1'b0; a_fl = 1'b0; a_din = '0;
    b_iv = 1'b1; b_or = 1'b0; b_fl = 1'b0; b_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst in_ready",  32'(a_ir),    32'(1));
    chk("rst out_valid", 32'(a_ov),    32'(0));
    chk("rst usage",     32'(a_usage), 32'(0));
    chk("rst we",        32'(a_we),    32'(0));
    chk("rst waddr",     32'(a_waddr), 32'(0));
    chk("rst raddr",     32'(a_raddr), 32'(0));
    chk("rst we64",      32'(b_we),    32'(0));
    a_iv = 1'b0; b_iv = 1'b0;
    rst_ni = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,0,0, 1,0,0,0,0,0));
    // single fall-through push
    tbl.push_back(mk(1,1,0,'h1ABCDEF, 1,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,0,         1,0,1,0,1,0));
    tbl.push_back(mk(0,1,0,0,         1,1,1,0,1,0));
    tbl.push_back(mk(0,1,0,0,         1,0,0,0,1,1));
    // fill to full without popping
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,0,0,'h100000 + i*7919, 1,(i >= 2),i,1,(1+i)%5,1));
    tbl.push_back(mk(1,0,0,'h0AAAAA, 0,1,5,0,1,1));
    // full with push and pop together: no write this cycle
    tbl.push_back(mk(1,1,0,'h0BBBBB, 0,1,5,0,1,1));
    // sustained push+pop, pointers wrap
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(1,1,0,'h155000 + k*31, 1,1,4,1,(1+k)%5,(2+k)%5));
    // drain
    tbl.push_back(mk(0,1,0,0, 1,1,4,0,3,4));
    tbl.push_back(mk(0,1,0,0, 1,1,3,0,3,0));
    tbl.push_back(mk(0,1,0,0, 1,1,2,0,3,1));
    tbl.push_back(mk(0,1,0,0, 1,1,1,0,3,2));
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,3,3));
    // push then flush on the next cycle
    tbl.push_back(mk(1,1,0,'h0DEAD1, 1,0,0,1,3,3));
    tbl.push_back(mk(1,1,1,'h0DEAD2, 0,0,1,0,4,3));
    tbl.push_back(mk(0,1,0,0,        1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,        1,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,'h0C0FFE, 1,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,0,        1,0,1,0,1,0));
    tbl.push_back(mk(0,1,0,0,        1,1,1,0,1,0));
    tbl.push_back(mk(0,1,0,0,        1,0,0,0,1,1));
    // three pushes ahead of an asynchronous reset
    tbl.push_back(mk(1,0,0,'h011111, 1,0,0,1,1,1));
    tbl.push_back(mk(1,0,0,'h022222, 1,0,1,1,2,1));
    tbl.push_back(mk(1,0,0,'h033333, 1,1,2,1,3,1));

    for (int i = 0; i < tbl.size(); i++) step5(tbl[i], i);

    // reset asserted mid-cycle while a push is being offered
    @(negedge clk);
    a_iv = 1'b1; a_or = 1'b0; a_din = 25'h044444;
    #1;
    chk("midrst pre usage", 32'(a_usage), 32'(3));
    chk("midrst pre we",    32'(a_we),    32'(1));
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst we",        32'(a_we),    32'(0));
    chk("midrst usage",     32'(a_usage), 32'(0));
    chk("midrst in_ready",  32'(a_ir),    32'(1));
    chk("midrst out_valid", 32'(a_ov),    32'(0));
    chk("midrst waddr",     32'(a_waddr), 32'(0));
    chk("midrst raddr",     32'(a_raddr), 32'(0));
    q5.delete();
    @(posedge clk); #1;
    chk("midrst hold we",   32'(a_we),    32'(0));
    @(negedge clk);
    a_iv = 1'b0; rst_ni = 1'b1;
    #1;
    chk("post rst in_ready",  32'(a_ir),    32'(1));
    chk("post rst out_valid", 32'(a_ov),    32'(0));
    chk("post rst usage",     32'(a_usage), 32'(0));
    step5(mk(1,1,0,'h055555, 1,0,0,1,0,0), 900);
    step5(mk(0,1,0,0,        1,0,1,0,1,0), 901);
    step5(mk(0,1,0,0,        1,1,1,0,1,0), 902);
    step5(mk(0,1,0,0,        1,0,0,0,1,1), 903);

    // random traffic on DEPTH=64 against a reference occupancy model
    mu = 0; mv = 0; mc = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      b_iv  = ($urandom_range(0, 1) == 1);
      if (c < 3000)      b_or = ($urandom_range(0, 3) == 0);
      else if (c < 6000) b_or = ($urandom_range(0, 3) != 0);
      else               b_or = ($urandom_range(0, 1) == 1);
      b_fl  = ($urandom_range(0, 499) == 0);
      b_din = 25'($urandom);
      #1;
      exp_ir = (mu < 64) && !b_fl;
      exp_ov = (mv != 0) && !b_fl;
      chk("d64 usage",     32'(b_usage), 32'(mu));
      chk("d64 in_ready",  32'(b_ir),    32'(exp_ir));
      chk("d64 out_valid", 32'(b_ov),    32'(exp_ov));
      chk("d64 we",        32'(b_we),    32'(b_iv && exp_ir));
      u = int'(b_usage);
      if (u > 64) chk("d64 usage_bound", 32'(u), 32'(64));
      push = b_iv && exp_ir;
      pop  = exp_ov && b_or;
      if (pop) begin
        if (q64.size() == 0) chk("d64 pop_on_empty_sb", 32'(1), 32'(0));
        else begin
          e = q64.pop_front();
          chk("d64 data", 32'(b_dout), 32'(e));
        end
      end
      if (push) q64.push_back(b_din);
      if (b_fl) begin
        q64.delete();
        mu = 0; mv = 0; mc = 0;
      end else begin
        mu = mu + int'(push) - int'(pop);
        mv = mv + mc - int'(pop);
        mc = int'(push);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
